// File: rtl/aclk_pkg.sv
// Shared types and time-validity helper for the alarm clock time-of-day counter.
package aclk_pkg;

   typedef logic [3:0]  bcd_digit_t;
   typedef logic [15:0] bcd_time_t;

   localparam bcd_digit_t MIN_TENS_MAX      = 4'd5;
   localparam bcd_digit_t HR_TENS_MAX       = 4'd2;
   localparam bcd_digit_t HR_ONES_MAX_AT_20 = 4'd3;

   function automatic logic bcd_time_valid(input bcd_time_t t);
      bcd_digit_t ht, ho, mt, mo;
      ht = t[15:12];
      ho = t[11:8];
      mt = t[7:4];
      mo = t[3:0];
      return (ht <= HR_TENS_MAX) && (ho <= 4'd9) && (mt <= MIN_TENS_MAX) && (mo <= 4'd9) &&
             !((ht == HR_TENS_MAX) && (ho > HR_ONES_MAX_AT_20));
   endfunction

endpackage

// File: rtl/aclk_bcd_digit.sv
// One BCD digit counting 0..MAX with load, clear, enable and a carry-out at MAX.
module aclk_bcd_digit
   import aclk_pkg::*;
#(
   parameter bcd_digit_t MAX       = 4'd9,
   parameter bcd_digit_t RESET_VAL = 4'd0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  bcd_digit_t load_val,
   input  logic       clear,
   input  logic       enable,
   output bcd_digit_t value,
   output logic       carry
);

   assign carry = enable && (value == MAX);

   always_ff @(posedge clock) begin
      if (!reset)
         value <= RESET_VAL;
      else if (load)
         value <= load_val;
      else if (clear)
         value <= 4'd0;
      else if (enable)
         value <= (value == MAX) ? 4'd0 : value + 4'd1;
   end

endmodule

// File: rtl/aclk_counter.sv
// Time-of-day counter HH:MM in BCD, advanced by one_second ticks and loadable from the key register.
module aclk_counter
   import aclk_pkg::*;
#(
   parameter int        TICKS_PER_MIN = 60,
   parameter bcd_time_t RESET_TIME    = 16'h0000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_second,
   input  logic       load_new_c,
   input  bcd_time_t  new_time,
   output bcd_time_t  current_time,
   output logic [5:0] sec_count,
   output logic       minute_pulse,
   output logic       day_wrap,
   output logic       load_ack,
   output logic       load_err
);

   localparam logic [5:0] SEC_LAST = 6'(TICKS_PER_MIN - 1);

   logic       load_ok;
   logic       minute_tick;
   logic       mo_carry, mt_carry, ho_carry, ht_carry;
   logic       day_end;
   bcd_digit_t mo, mt, ho, ht;

   assign load_ok     = load_new_c && bcd_time_valid(new_time);
   assign minute_tick = one_second && !load_new_c && (sec_count == SEC_LAST);
   // 23:59 rolls the hour pair straight to 00, overriding the normal hr_ones advance
   assign day_end     = mt_carry && (ht == HR_TENS_MAX) && (ho == HR_ONES_MAX_AT_20);

   aclk_bcd_digit #(.MAX(4'd9), .RESET_VAL(RESET_TIME[3:0])) u_min_ones (
      .clock(clock), .reset(reset), .load(load_ok), .load_val(new_time[3:0]),
      .clear(1'b0), .enable(minute_tick), .value(mo), .carry(mo_carry));

   aclk_bcd_digit #(.MAX(MIN_TENS_MAX), .RESET_VAL(RESET_TIME[7:4])) u_min_tens (
      .clock(clock), .reset(reset), .load(load_ok), .load_val(new_time[7:4]),
      .clear(1'b0), .enable(mo_carry), .value(mt), .carry(mt_carry));

   aclk_bcd_digit #(.MAX(4'd9), .RESET_VAL(RESET_TIME[11:8])) u_hr_ones (
      .clock(clock), .reset(reset), .load(load_ok), .load_val(new_time[11:8]),
      .clear(day_end), .enable(mt_carry), .value(ho), .carry(ho_carry));

   aclk_bcd_digit #(.MAX(HR_TENS_MAX), .RESET_VAL(RESET_TIME[15:12])) u_hr_tens (
      .clock(clock), .reset(reset), .load(load_ok), .load_val(new_time[15:12]),
      .clear(day_end), .enable(ho_carry), .value(ht), .carry(ht_carry));

   assign current_time = {ht, ho, mt, mo};

   always_ff @(posedge clock) begin
      if (!reset) begin
         sec_count    <= 6'd0;
         minute_pulse <= 1'b0;
         day_wrap     <= 1'b0;
         load_ack     <= 1'b0;
         load_err     <= 1'b0;
      end else begin
         minute_pulse <= minute_tick;
         day_wrap     <= day_end;
         load_ack     <= load_ok;
         load_err     <= load_new_c && !load_ok;
         if (load_ok || minute_tick)
            sec_count <= 6'd0;
         else if (one_second && !load_new_c)
            sec_count <= sec_count + 6'd1;
      end
   end

   logic unused_carry;
   assign unused_carry = ht_carry;

endmodule

// File: tb/tb_aclk_counter.sv
// Directed self-checking bench for aclk_counter with a 4-tick minute.
module tb_aclk_counter;

   logic        clock = 1'b0;
   logic        reset;
   logic        one_second;
   logic        load_new_c;
   logic [15:0] new_time;
   logic [15:0] current_time;
   logic [5:0]  sec_count;
   logic        minute_pulse, day_wrap, load_ack, load_err;

   int n_checks = 0;
   int n_errors = 0;

   aclk_counter #(.TICKS_PER_MIN(4), .RESET_TIME(16'h0000)) dut (
      .clock(clock), .reset(reset), .one_second(one_second), .load_new_c(load_new_c),
      .new_time(new_time), .current_time(current_time), .sec_count(sec_count),
      .minute_pulse(minute_pulse), .day_wrap(day_wrap), .load_ack(load_ack),
      .load_err(load_err));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // apply inputs across one rising edge, then release them just after it
   task automatic step(input logic ld, input logic os, input logic [15:0] nt);
      load_new_c = ld;
      one_second = os;
      new_time   = nt;
      @(posedge clock);
      #1;
      load_new_c = 1'b0;
      one_second = 1'b0;
   endtask

   task automatic check_pulses(input string tag, input logic mp, input logic dw,
                               input logic ack, input logic err);
      check({tag, "_mp"},  16'(minute_pulse), 16'(mp));
      check({tag, "_dw"},  16'(day_wrap),     16'(dw));
      check({tag, "_ack"}, 16'(load_ack),     16'(ack));
      check({tag, "_err"}, 16'(load_err),     16'(err));
   endtask

   initial begin
      reset = 1'b0; one_second = 1'b0; load_new_c = 1'b0; new_time = 16'h0;

      // 1: reset
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      check("rst_time", current_time, 16'h0000);
      check("rst_sec", 16'(sec_count), 16'd0);
      check_pulses("rst", 0, 0, 0, 0);

      // 2: 12:59 -> 13:00
      step(1, 0, 16'h1259);
      check("ld1259_time", current_time, 16'h1259);
      check("ld1259_ack", 16'(load_ack), 16'd1);
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, 16'h0);
         check("tick_sec", 16'(sec_count), 16'(i));
         check("tick_mp", 16'(minute_pulse), 16'd0);
      end
      step(0, 1, 16'h0);
      check("wrap1300_time", current_time, 16'h1300);
      check("wrap1300_sec", 16'(sec_count), 16'd0);
      check_pulses("wrap1300", 1, 0, 0, 0);
      step(0, 0, 16'h0);
      check_pulses("idle", 0, 0, 0, 0);

      // hour-ones carry 09:59 -> 10:00 and 19:59 -> 20:00
      step(1, 0, 16'h0959);
      repeat (4) step(0, 1, 16'h0);
      check("wrap1000_time", current_time, 16'h1000);
      step(1, 0, 16'h1959);
      repeat (4) step(0, 1, 16'h0);
      check("wrap2000_time", current_time, 16'h2000);
      check("wrap2000_dw", 16'(day_wrap), 16'd0);

      // 3: 23:59 -> 00:00
      step(1, 0, 16'h2359);
      repeat (3) step(0, 1, 16'h0);
      check("pre_day_dw", 16'(day_wrap), 16'd0);
      step(0, 1, 16'h0);
      check("day_time", current_time, 16'h0000);
      check_pulses("day", 1, 1, 0, 0);
      step(0, 0, 16'h0);
      check("day_dw_clr", 16'(day_wrap), 16'd0);

      // 4: invalid loads hold state
      step(1, 0, 16'h1122);
      step(0, 1, 16'h0);
      step(1, 0, 16'h2400);
      check("bad2400_time", current_time, 16'h1122);
      check("bad2400_sec", 16'(sec_count), 16'd1);
      check_pulses("bad2400", 0, 0, 0, 1);
      step(1, 0, 16'h1A00);
      check("bad1A00_time", current_time, 16'h1122);
      check_pulses("bad1A00", 0, 0, 0, 1);
      step(1, 1, 16'h0960);
      check("bad0960_time", current_time, 16'h1122);
      check("bad0960_sec", 16'(sec_count), 16'd1);
      check_pulses("bad0960", 0, 0, 0, 1);

      // 5: load beats tick
      step(0, 1, 16'h0);
      check("pre_sec", 16'(sec_count), 16'd2);
      step(1, 1, 16'h0815);
      check("ldtick_time", current_time, 16'h0815);
      check("ldtick_sec", 16'(sec_count), 16'd0);
      check_pulses("ldtick", 0, 0, 1, 0);

      // 6: reset mid-count
      step(1, 0, 16'h0959);
      repeat (3) step(0, 1, 16'h0);
      check("mid_sec", 16'(sec_count), 16'd3);
      reset = 1'b0;
      step(1, 1, 16'h1234);
      reset = 1'b1;
      check("midrst_time", current_time, 16'h0000);
      check("midrst_sec", 16'(sec_count), 16'd0);
      check_pulses("midrst", 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
